// File: rtl/calc_pkg.sv
// Shared calculator constants: key codes, operator codes, entry FSM states.
// Imported by the keypad entry path and the display path.
package calc_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HOLD,
        S_RELEASE
    } kp_state_e;

    // Snapshot bit index is row*4+col, rows top to bottom.
    function automatic logic [3:0] key_of_idx(input logic [3:0] idx);
        logic [3:0] k;
        case (idx)
            4'd0:    k = KEY_1;
            4'd1:    k = KEY_2;
            4'd2:    k = KEY_3;
            4'd3:    k = KEY_A;
            4'd4:    k = KEY_4;
            4'd5:    k = KEY_5;
            4'd6:    k = KEY_6;
            4'd7:    k = KEY_B;
            4'd8:    k = KEY_7;
            4'd9:    k = KEY_8;
            4'd10:   k = KEY_9;
            4'd11:   k = KEY_C;
            4'd12:   k = KEY_STAR;
            4'd13:   k = KEY_0;
            4'd14:   k = KEY_HASH;
            default: k = KEY_D;
        endcase
        return k;
    endfunction

    function automatic logic [1:0] op_of_key(input logic [3:0] k);
        logic [3:0] t;
        t = k - KEY_A;
        return t[1:0];
    endfunction

endpackage

// File: rtl/keypad_matrix_scan.sv
// Drives keypad rows in turn and assembles a 16-bit pressed-key snapshot.
// scan_end pulses once the row-3 columns have landed in the snapshot.
module keypad_matrix_scan #(
    parameter logic [19:0] SCAN_CNT_MAX = 20'd200_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic [15:0] snapshot,
    output logic        scan_end
);

    logic [3:0]  sync1_q;
    logic [3:0]  sync2_q;
    logic [19:0] scan_cnt_q;
    logic [1:0]  row_q;
    logic [15:0] snap_q;
    logic [15:0] snap_d;
    logic        scan_end_q;
    logic        tc;

    assign tc = (scan_cnt_q == SCAN_CNT_MAX - 20'd1);

    always_comb begin
        snap_d = snap_q;
        if (tc) begin
            snap_d[{row_q, 2'b00} +: 4] = ~sync2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 4'hF;
            sync2_q    <= 4'hF;
            scan_cnt_q <= '0;
            row_q      <= '0;
            snap_q     <= '0;
            scan_end_q <= 1'b0;
        end else begin
            sync1_q    <= col_n;
            sync2_q    <= sync1_q;
            scan_cnt_q <= tc ? 20'd0 : scan_cnt_q + 20'd1;
            if (tc) begin
                row_q <= row_q + 2'd1;
            end
            snap_q     <= snap_d;
            scan_end_q <= tc && (row_q == 2'd3);
        end
    end

    assign row_n    = ~(4'b0001 << row_q);
    assign snapshot = snap_q;
    assign scan_end = scan_end_q;

endmodule

// File: rtl/calculator_keypad_entry.sv
// Keypad entry: debounces scanned presses and builds a hex operand,
// emitting operand/operator handshakes toward the calculator core.
module calculator_keypad_entry
    import calc_pkg::*;
#(
    parameter logic [19:0] SCAN_CNT_MAX   = 20'd200_000,
    parameter logic [2:0]  DEBOUNCE_SCANS = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] operand,
    output logic [3:0]  digit_cnt,
    output logic        overflow,
    output logic        operand_valid,
    output logic        op_valid,
    output logic [1:0]  op_code
);

    logic [15:0] snapshot;
    logic        scan_end;
    logic        single;
    logic        empty;
    logic [3:0]  key_idx;
    logic [3:0]  key;

    kp_state_e   state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [2:0]  stable_q, stable_d;
    logic        accept;

    logic [31:0] operand_q, operand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        fresh_q, fresh_d;
    logic [3:0]  code_q, code_d;
    logic [1:0]  opc_q, opc_d;
    logic        kv_q, kv_d;
    logic        ovld_q, ovld_d;
    logic        opv_q, opv_d;

    keypad_matrix_scan #(
        .SCAN_CNT_MAX (SCAN_CNT_MAX)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .snapshot (snapshot),
        .scan_end (scan_end)
    );

    assign empty  = (snapshot == 16'd0);
    assign single = !empty && ((snapshot & (snapshot - 16'd1)) == 16'd0);

    always_comb begin
        key_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                key_idx = 4'(i);
            end
        end
    end

    assign key = key_of_idx(key_idx);

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                S_IDLE: begin
                    if (single) begin
                        state_d  = S_DEBOUNCE;
                        cand_d   = key;
                        stable_d = 3'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (single && key == cand_q) begin
                        stable_d = stable_q + 3'd1;
                        if (stable_q + 3'd1 >= DEBOUNCE_SCANS) begin
                            accept  = 1'b1;
                            state_d = S_HOLD;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (empty) begin
                        state_d  = S_RELEASE;
                        stable_d = 3'd1;
                    end
                end
                S_RELEASE: begin
                    if (empty) begin
                        stable_d = stable_q + 3'd1;
                        if (stable_q + 3'd1 >= DEBOUNCE_SCANS) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        operand_d = operand_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        fresh_d   = fresh_q;
        code_d    = code_q;
        opc_d     = opc_q;
        kv_d      = 1'b0;
        ovld_d    = 1'b0;
        opv_d     = 1'b0;
        if (accept) begin
            kv_d   = 1'b1;
            code_d = cand_q;
            if (cand_q <= KEY_9) begin
                // First digit after an operator starts a new operand.
                if (fresh_q || cnt_q == 4'd0) begin
                    operand_d = {28'd0, cand_q};
                    cnt_d     = 4'd1;
                    fresh_d   = 1'b0;
                end else if (cnt_q < 4'(MAX_DIGITS)) begin
                    operand_d = {operand_q[27:0], cand_q};
                    cnt_d     = cnt_q + 4'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (cand_q == KEY_STAR) begin
                operand_d = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
                fresh_d   = 1'b0;
            end else if (cand_q == KEY_HASH) begin
                ovld_d  = 1'b1;
                fresh_d = 1'b1;
            end else begin
                ovld_d  = 1'b1;
                opv_d   = 1'b1;
                opc_d   = op_of_key(cand_q);
                fresh_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cand_q    <= '0;
            stable_q  <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            fresh_q   <= 1'b0;
            code_q    <= '0;
            opc_q     <= OP_ADD;
            kv_q      <= 1'b0;
            ovld_q    <= 1'b0;
            opv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            fresh_q   <= fresh_d;
            code_q    <= code_d;
            opc_q     <= opc_d;
            kv_q      <= kv_d;
            ovld_q    <= ovld_d;
            opv_q     <= opv_d;
        end
    end

    assign key_valid     = kv_q;
    assign key_code      = code_q;
    assign operand       = operand_q;
    assign digit_cnt     = cnt_q;
    assign overflow      = ovf_q;
    assign operand_valid = ovld_q;
    assign op_valid      = opv_q;
    assign op_code       = opc_q;

endmodule

// File: doc/calculator_keypad_entry.md
Name: calculator_keypad_entry

Overview:
Input-side counterpart of the calculator display path. Scans a 4x4 active-low matrix keypad and debounces key presses. Converts presses into key events and assembles a 32-bit hex operand, one nibble per digit, in the same format the display path consumes. Emits operand/operator handshakes toward the calculator core.

Parameters:
SCAN_CNT_MAX, 20'd200_000, clocks each row is driven before its columns are sampled (bench uses 20'd5)
DEBOUNCE_SCANS, 3'd3, consecutive identical full scans required to accept a press or a release (bench uses 3'd2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
row_n  out  4  keypad row drive, active-low one-hot
col_n  in  4  keypad columns, active-low, asynchronous, externally pulled up
key_valid  out  1  one-cycle pulse per accepted press
key_code  out  4  code of the last accepted key, held until the next press
operand  out  32  current operand, nibble 0 = last digit entered
digit_cnt  out  4  number of digits in operand, 0..8
overflow  out  1  sticky flag: a 9th digit was attempted
operand_valid  out  1  one-cycle pulse: operand is final (operator or '#')
op_valid  out  1  one-cycle pulse, coincident with operand_valid for operator keys
op_code  out  2  0 add (A), 1 sub (B), 2 mul (C), 3 div (D); held until the next operator

Behaviour:
- Reset values: row_n=4'b1110, key_code=0, operand=0, digit_cnt=0, overflow=0, all pulses 0, FSM=S_IDLE, scan_cnt=0, row=0, fresh=0.
- col_n passes through a 2-flop synchroniser before any use.
- scan_cnt counts 0..SCAN_CNT_MAX-1 and wraps. At the terminal count:
  - the inverted synced col_n is written into snapshot bits [row*4 +: 4];
  - row advances (3 wraps to 0) and row_n updates on the same edge.
- scan_end is a one-cycle strobe after the row-3 sample. The completed 16-bit snapshot is evaluated only on scan_end.
- Key map, row-major (snapshot bit r*4+c): row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = * 0 # D. Codes: digits 0-9 give 0x0-0x9, A-D give 0xA-0xD, '*' gives 0xE, '#' gives 0xF.
- "single" means the snapshot has exactly one bit set. "empty" means the snapshot is zero.
- FSM, evaluated on scan_end only:
  - S_IDLE: single -> S_DEBOUNCE, cand=key, stable=1. Otherwise stay.
  - S_DEBOUNCE: single and same as cand -> stable+1. When stable reaches DEBOUNCE_SCANS -> accept the key and go to S_HOLD. Any other snapshot -> S_IDLE.
  - S_HOLD: empty -> S_RELEASE, stable=1. Otherwise stay; extra keys pressed here are ignored.
  - S_RELEASE: empty -> stable+1; at DEBOUNCE_SCANS -> S_IDLE. Non-empty -> S_HOLD.
- Accept: on the clock edge after the accepting scan_end, key_valid=1, key_code=cand, and the key action below completes on the same edge.
- Key actions:
  - Digit, with fresh=1 or digit_cnt=0: operand={28'b0,d}, digit_cnt=1, fresh=0.
  - Digit, digit_cnt<8: operand={operand[27:0],d}, digit_cnt+1.
  - Digit, digit_cnt==8: operand unchanged, overflow=1.
  - A-D: operand_valid=1, op_valid=1, op_code per map, fresh=1. operand stays visible.
  - '#': operand_valid=1, op_valid=0, fresh=1.
  - '*': operand=0, digit_cnt=0, overflow=0, fresh=0. No handshake pulse.
- Latency: at most 4*SCAN_CNT_MAX*(DEBOUNCE_SCANS+1)+3 clocks from a stable press to key_valid.
- A press held indefinitely yields exactly one key_valid. There is no auto-repeat.
- rst asserted mid-scan or mid-debounce returns everything to reset values immediately. A key still held when rst deasserts is accepted as a new press.

Decomposition:
- Shared package calc_pkg:
  - key codes KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR=4'hE, KEY_HASH=4'hF;
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - FSM state encodings;
  - MAX_DIGITS=8.
  The display path imports the same digit-count constant.
- Sub-module keypad_matrix_scan owns the synchroniser, scan_cnt, row drive and snapshot assembly. It outputs snapshot[15:0] and scan_end.
- The top level holds the FSM, key map and operand logic.

Test Plan:
- Reset with a key held: reset values hold during rst. After release, 2 stable scans give key_valid with the correct code; an immediate press gives no event.
- Press '1','2','3' cleanly -> three key_valid pulses, operand=32'h0000_0123, digit_cnt=3, no operand_valid.
- Bouncing '5' (toggled every scan for 3 scans, then stable) -> exactly one key_valid, key_code=5. A single-scan glitch gives no event.
- Enter 9 digits 1..9 -> operand=32'h1234_5678, digit_cnt=8, overflow=1. Then '*' -> operand=0, digit_cnt=0, overflow=0.
- Sequence '4','2','B','7' -> on B: operand_valid=op_valid=1 for one cycle, op_code=1, operand=32'h42. On 7: operand=32'h7, digit_cnt=1.
- Hold '#' for 20 scans while pressing '3' mid-hold -> one key_valid (code F) with operand_valid, no event for '3'. Release for 2 empty scans, then press '3' -> new event with code 3.
